// File: rtl/soc_node_pkg.sv
// rtl/soc_node_pkg.sv - shared types and constants for the SoC node responders
package soc_node_pkg;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Recognisable filler returned on reads from unmapped space
   localparam logic [63:0] RDATA_PATTERN_DEFAULT = 64'hBADC_AB1E_DEAD_BEEF;

   // AXI4 bursts are at most 256 beats, so an 8-bit remaining-beat counter suffices
   localparam int unsigned BEAT_CNT_W = 8;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/axi_bus_intf.sv
// rtl/axi_bus_intf.sv - AXI4 bus bundle with a slave-side modport
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 8,
   parameter int unsigned AXI_USER_WIDTH = 6
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_qos;
   logic [3:0]                  aw_region;
   logic [5:0]                  aw_atop;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_qos;
   logic [3:0]                  ar_region;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_atop, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/soc_node_sat_cnt.sv
// rtl/soc_node_sat_cnt.sv - saturating event counter with priority clear
module soc_node_sat_cnt #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] r_cnt;

   // Count up to all-ones and hold; clear wins over a same-cycle increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/soc_node_decerr_slv.sv
// rtl/soc_node_decerr_slv.sv - AXI4 error responder terminating an unused crossbar port
module soc_node_decerr_slv
   import soc_node_pkg::*;
#(
   parameter int unsigned AXI_AW        = 32,
   parameter int unsigned AXI_DW        = 64,
   parameter int unsigned AXI_IW        = 8,
   parameter int unsigned AXI_UW        = 6,
   parameter logic [1:0]  RESP          = RESP_DECERR,
   parameter logic [63:0] RDATA_PATTERN = RDATA_PATTERN_DEFAULT,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   AXI_BUS.Slave             slv,
   input  logic              clr_i,
   output logic [CNT_W-1:0]  err_cnt_wr_o,
   output logic [CNT_W-1:0]  err_cnt_rd_o,
   output logic [AXI_AW-1:0] err_addr_o,
   output logic              err_is_write_o,
   output logic              err_valid_o
);

   localparam logic [AXI_DW-1:0] RDATA_VAL = AXI_DW'(RDATA_PATTERN);

   w_state_e               r_w_state;
   w_state_e               w_w_next;
   logic [BEAT_CNT_W-1:0]  r_w_cnt;
   logic [AXI_IW-1:0]      r_bid;
   r_state_e               r_r_state;
   r_state_e               w_r_next;
   logic [BEAT_CNT_W-1:0]  r_r_cnt;
   logic [AXI_IW-1:0]      r_rid;
   logic                   w_awready;
   logic                   w_wready;
   logic                   w_bvalid;
   logic                   w_arready;
   logic                   w_rvalid;
   logic                   w_aw_hs;
   logic                   w_w_hs;
   logic                   w_ar_hs;
   logic                   w_r_hs;
   logic                   w_r_last;
   logic [AXI_AW-1:0]      r_err_addr;
   logic                   r_err_is_write;
   logic                   r_err_valid;
   logic                   w_unused;

   assign w_aw_hs  = slv.aw_valid & w_awready;
   assign w_w_hs   = slv.w_valid & w_wready;
   assign w_ar_hs  = slv.ar_valid & w_arready;
   assign w_r_hs   = w_rvalid & slv.r_ready;
   assign w_r_last = (r_r_state == R_DATA) && (r_r_cnt == '0);

   // Write path state, beat counter and latched ID
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_w_state <= W_IDLE;
         r_w_cnt   <= '0;
         r_bid     <= '0;
      end else begin
         r_w_state <= w_w_next;
         if (w_aw_hs) begin
            r_w_cnt <= slv.aw_len;
            r_bid   <= slv.aw_id;
         end else if (w_w_hs && (r_w_cnt != '0)) begin
            r_w_cnt <= r_w_cnt - BEAT_CNT_W'(1);
         end
      end
   end

   // Write path next state and handshake outputs; burst ends on beat count, not WLAST
   always_comb begin
      w_w_next  = r_w_state;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_bvalid  = 1'b0;
      unique case (r_w_state)
         W_IDLE: begin
            w_awready = 1'b1;
            if (slv.aw_valid) w_w_next = W_DATA;
         end
         W_DATA: begin
            w_wready = 1'b1;
            if (slv.w_valid && (r_w_cnt == '0)) w_w_next = W_RESP;
         end
         W_RESP: begin
            w_bvalid = 1'b1;
            if (slv.b_ready) w_w_next = W_IDLE;
         end
         default: w_w_next = W_IDLE;
      endcase
   end

   // Read path state, remaining-beat counter and latched ID
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_r_state <= R_IDLE;
         r_r_cnt   <= '0;
         r_rid     <= '0;
      end else begin
         r_r_state <= w_r_next;
         if (w_ar_hs) begin
            r_r_cnt <= slv.ar_len;
            r_rid   <= slv.ar_id;
         end else if (w_r_hs && (r_r_cnt != '0)) begin
            r_r_cnt <= r_r_cnt - BEAT_CNT_W'(1);
         end
      end
   end

   // Read path next state and handshake outputs
   always_comb begin
      w_r_next  = r_r_state;
      w_arready = 1'b0;
      w_rvalid  = 1'b0;
      unique case (r_r_state)
         R_IDLE: begin
            w_arready = 1'b1;
            if (slv.ar_valid) w_r_next = R_DATA;
         end
         R_DATA: begin
            w_rvalid = 1'b1;
            if (slv.r_ready && (r_r_cnt == '0)) w_r_next = R_IDLE;
         end
         default: w_r_next = R_IDLE;
      endcase
   end

   assign slv.aw_ready = w_awready;
   assign slv.w_ready  = w_wready;
   assign slv.b_valid  = w_bvalid;
   assign slv.b_id     = r_bid;
   assign slv.b_resp   = RESP;
   assign slv.b_user   = {AXI_UW{1'b0}};
   assign slv.ar_ready = w_arready;
   assign slv.r_valid  = w_rvalid;
   assign slv.r_id     = r_rid;
   assign slv.r_data   = RDATA_VAL;
   assign slv.r_resp   = RESP;
   assign slv.r_last   = w_r_last;
   assign slv.r_user   = {AXI_UW{1'b0}};

   soc_node_sat_cnt #(.WIDTH(CNT_W)) u_cnt_wr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_aw_hs),
      .clr_i  (clr_i),
      .cnt_o  (err_cnt_wr_o)
   );

   soc_node_sat_cnt #(.WIDTH(CNT_W)) u_cnt_rd (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_ar_hs),
      .clr_i  (clr_i),
      .cnt_o  (err_cnt_rd_o)
   );

   // Sticky capture of the first error; a write wins a same-cycle tie, clear wins over both
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_addr     <= '0;
         r_err_is_write <= 1'b0;
         r_err_valid    <= 1'b0;
      end else if (clr_i) begin
         r_err_addr     <= '0;
         r_err_is_write <= 1'b0;
         r_err_valid    <= 1'b0;
      end else if (!r_err_valid) begin
         if (w_aw_hs) begin
            r_err_addr     <= slv.aw_addr;
            r_err_is_write <= 1'b1;
            r_err_valid    <= 1'b1;
         end else if (w_ar_hs) begin
            r_err_addr     <= slv.ar_addr;
            r_err_is_write <= 1'b0;
            r_err_valid    <= 1'b1;
         end
      end
   end

   assign err_addr_o     = r_err_addr;
   assign err_is_write_o = r_err_is_write;
   assign err_valid_o    = r_err_valid;

   // Attributes and write payload are deliberately discarded
   assign w_unused = ^{slv.aw_size, slv.aw_burst, slv.aw_lock, slv.aw_cache, slv.aw_prot,
                       slv.aw_qos, slv.aw_region, slv.aw_atop, slv.aw_user,
                       slv.w_data, slv.w_strb, slv.w_last, slv.w_user,
                       slv.ar_size, slv.ar_burst, slv.ar_lock, slv.ar_cache, slv.ar_prot,
                       slv.ar_qos, slv.ar_region, slv.ar_user};

endmodule

// File: tb/tb_soc_node_decerr_slv.sv
// tb/tb_soc_node_decerr_slv.sv - randomized self-checking bench for soc_node_decerr_slv
module tb_soc_node_decerr_slv;

   localparam int unsigned CNT_W = 10;
   localparam logic [63:0] PAT   = 64'hBADC_AB1E_DEAD_BEEF;

   typedef struct packed {
      logic [7:0]  id;
      logic [7:0]  len;
      logic [31:0] addr;
   } burst_t;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   logic [CNT_W-1:0] cnt_wr, cnt_rd;
   logic [31:0] err_addr;
   logic err_is_write, err_valid;

   int checks = 0;
   int failures = 0;

   int m_wr, m_rd;
   logic m_cap_valid, m_cap_wr;
   logic [31:0] m_cap_addr;
   burst_t aw_q[$];
   burst_t ar_q[$];

   AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(6)) bus ();

   soc_node_decerr_slv #(.CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .slv            (bus),
      .clr_i          (clr),
      .err_cnt_wr_o   (cnt_wr),
      .err_cnt_rd_o   (cnt_rd),
      .err_addr_o     (err_addr),
      .err_is_write_o (err_is_write),
      .err_valid_o    (err_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic burst_t mk(input logic [7:0] id, input logic [7:0] len);
      burst_t b;
      b.id   = id;
      b.len  = len;
      b.addr = $urandom;
      return b;
   endfunction

   function automatic logic [CNT_W-1:0] sat_val(input int n);
      if (n >= (1 << CNT_W) - 1) return {CNT_W{1'b1}};
      return CNT_W'(n);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = 3'd3; bus.aw_burst = 2'd1;
      bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0;
      bus.aw_atop = '0; bus.aw_user = '0; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '1; bus.w_last = 1'b0; bus.w_user = '0; bus.w_valid = 1'b0;
      bus.b_ready = 1'b0;
      bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = 3'd3; bus.ar_burst = 2'd1;
      bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0;
      bus.ar_user = '0; bus.ar_valid = 1'b0;
      bus.r_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_wr = 0; m_rd = 0; m_cap_valid = 1'b0; m_cap_wr = 1'b0; m_cap_addr = '0;
      aw_q.delete();
      ar_q.delete();
   endtask

   // Drives everything queued in aw_q/ar_q to completion, checking each cycle against
   // transaction-level expectations, then checks counters and capture against the model.
   task automatic run_traffic(input int w_gap, input int rready_pct, input int bready_pct,
                              input int bready_hold, input bit early_w, input bit clr_first,
                              input int max_cycles, input string name);
      burst_t wc, rc;
      bit w_busy = 0, r_busy = 0;
      int w_beats = 0, r_beats = 0, b_wait = 0, cyc = 0;
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs, clr_now, lst;
      logic [4:0] e_vr, a_vr;
      logic [80:0] e_r, a_r;
      logic [15:0] e_b, a_b;
      wc = '0;
      rc = '0;
      while (aw_q.size() > 0 || ar_q.size() > 0 || w_busy || r_busy) begin
         if (cyc >= max_cycles) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: cycles=%0d limit=%0d", name, cyc, max_cycles);
            break;
         end
         clr_now = clr_first && (cyc == 0);
         clr = clr_now;
         bus.aw_valid = (aw_q.size() > 0);
         if (aw_q.size() > 0) begin
            bus.aw_id = aw_q[0].id; bus.aw_len = aw_q[0].len; bus.aw_addr = aw_q[0].addr;
         end
         if (!bus.w_valid) begin
            if ((w_busy && (w_beats < int'(wc.len) + 1)) || (early_w && !w_busy && aw_q.size() > 0)) begin
               bus.w_valid = ($urandom_range(99) >= w_gap);
               bus.w_data  = {$urandom, $urandom};
               bus.w_last  = w_busy && (w_beats == int'(wc.len));
            end
         end
         if (bready_hold > 0) bus.b_ready = (b_wait >= bready_hold);
         else                 bus.b_ready = ($urandom_range(99) < bready_pct);
         bus.ar_valid = (ar_q.size() > 0);
         if (ar_q.size() > 0) begin
            bus.ar_id = ar_q[0].id; bus.ar_len = ar_q[0].len; bus.ar_addr = ar_q[0].addr;
         end
         bus.r_ready = ($urandom_range(99) < rready_pct);

         e_vr = {!w_busy, w_busy && (w_beats < int'(wc.len) + 1), w_busy && (w_beats == int'(wc.len) + 1),
                 !r_busy, r_busy};
         a_vr = {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid};
         checks++;
         if (a_vr !== e_vr) begin
            failures++;
            $display("FAIL %s handshake cycle=%0d {awr,wr,bv,arr,rv} got=%b exp=%b", name, cyc, a_vr, e_vr);
         end
         if (e_vr[2]) begin
            e_b = {wc.id, 2'b11, 6'h00};
            a_b = {bus.b_id, bus.b_resp, bus.b_user};
            checks++;
            if (a_b !== e_b) begin
               failures++;
               $display("FAIL %s bfields cycle=%0d got=%h exp=%h", name, cyc, a_b, e_b);
            end
         end
         if (e_vr[0]) begin
            lst = (r_beats == int'(rc.len));
            e_r = {rc.id, 2'b11, PAT, lst, 6'h00};
            a_r = {bus.r_id, bus.r_resp, bus.r_data, bus.r_last, bus.r_user};
            checks++;
            if (a_r !== e_r) begin
               failures++;
               $display("FAIL %s rfields cycle=%0d beat=%0d got=%h exp=%h", name, cyc, r_beats, a_r, e_r);
            end
         end

         aw_hs = bus.aw_valid && bus.aw_ready;
         w_hs  = bus.w_valid && bus.w_ready;
         b_hs  = bus.b_valid && bus.b_ready;
         ar_hs = bus.ar_valid && bus.ar_ready;
         r_hs  = bus.r_valid && bus.r_ready;
         @(posedge clk);
         #1;
         cyc++;

         if (clr_now) begin
            m_wr = 0; m_rd = 0; m_cap_valid = 1'b0;
         end else begin
            if (aw_hs) m_wr++;
            if (ar_hs) m_rd++;
            if (!m_cap_valid && (aw_hs || ar_hs)) begin
               m_cap_valid = 1'b1;
               m_cap_wr    = aw_hs;
               m_cap_addr  = aw_hs ? aw_q[0].addr : ar_q[0].addr;
            end
         end
         if (aw_hs) begin
            wc = aw_q.pop_front(); w_busy = 1; w_beats = 0; b_wait = 0;
         end
         if (w_hs) begin
            w_beats++;
            bus.w_valid = 1'b0;
         end
         if (b_hs) w_busy = 0;
         else if (bus.b_valid) b_wait++;
         if (ar_hs) begin
            rc = ar_q.pop_front(); r_busy = 1; r_beats = 0;
         end
         if (r_hs) begin
            if (r_beats == int'(rc.len)) r_busy = 0;
            else r_beats++;
         end
      end
      clr = 1'b0;
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
      bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

      checks++;
      if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid} !== 5'b10010) begin
         failures++;
         $display("FAIL %s idle_after: got=%b exp=10010", name,
                  {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid});
      end
      checks++;
      if (cnt_wr !== sat_val(m_wr)) begin
         failures++;
         $display("FAIL %s cnt_wr: got=%0d exp=%0d", name, cnt_wr, sat_val(m_wr));
      end
      checks++;
      if (cnt_rd !== sat_val(m_rd)) begin
         failures++;
         $display("FAIL %s cnt_rd: got=%0d exp=%0d", name, cnt_rd, sat_val(m_rd));
      end
      checks++;
      if (err_valid !== m_cap_valid) begin
         failures++;
         $display("FAIL %s err_valid: got=%b exp=%b", name, err_valid, m_cap_valid);
      end
      if (m_cap_valid) begin
         checks++;
         if ({err_addr, err_is_write} !== {m_cap_addr, m_cap_wr}) begin
            failures++;
            $display("FAIL %s capture: got addr=%h wr=%b exp addr=%h wr=%b",
                     name, err_addr, err_is_write, m_cap_addr, m_cap_wr);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid} !== 5'b10010) begin
         failures++;
         $display("FAIL reset_handshake: got=%b exp=10010",
                  {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid});
      end
      checks++;
      if ({bus.b_id, bus.r_id, bus.r_last} !== 17'h0) begin
         failures++;
         $display("FAIL reset_ids: got=%h exp=0", {bus.b_id, bus.r_id, bus.r_last});
      end
      checks++;
      if ({cnt_wr, cnt_rd} !== '0) begin
         failures++;
         $display("FAIL reset_counters: got wr=%0d rd=%0d exp 0", cnt_wr, cnt_rd);
      end
      checks++;
      if ({err_addr, err_is_write, err_valid} !== 34'h0) begin
         failures++;
         $display("FAIL reset_capture: got=%h exp=0", {err_addr, err_is_write, err_valid});
      end
   endtask

   task automatic test_read_basic();
      ar_q.push_back(mk(8'h2A, 8'd3));
      run_traffic(0, 100, 100, 0, 1'b0, 1'b0, 50, "read_basic");
   endtask

   task automatic test_write_bhold();
      aw_q.push_back(mk(8'h05, 8'd0));
      aw_q.push_back(mk(8'h6B, 8'd0));
      run_traffic(0, 100, 100, 5, 1'b0, 1'b0, 60, "write_bhold");
   endtask

   task automatic test_long_burst();
      aw_q.push_back(mk(8'($urandom), 8'd255));
      ar_q.push_back(mk(8'($urandom), 8'd7));
      run_traffic(30, 50, 50, 0, 1'b1, 1'b0, 3000, "long_burst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         aw_q.push_back(mk(8'($urandom), 8'($urandom_range(15))));
         ar_q.push_back(mk(8'($urandom), 8'($urandom_range(15))));
      end
      run_traffic(40, 60, 60, 0, 1'b1, 1'b0, 3000, "random");
   endtask

   task automatic test_simultaneous_and_clear();
      do_reset();
      aw_q.push_back(mk(8'h11, 8'd0));
      ar_q.push_back(mk(8'h22, 8'd0));
      run_traffic(0, 100, 100, 0, 1'b0, 1'b0, 50, "simultaneous");
      ar_q.push_back(mk(8'h33, 8'd1));
      run_traffic(0, 100, 100, 0, 1'b0, 1'b1, 50, "clear_with_ar");
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < (1 << CNT_W) + 3; i++) ar_q.push_back(mk(8'($urandom), 8'd0));
      run_traffic(0, 100, 100, 0, 1'b0, 1'b0, 6000, "saturate");
      checks++;
      if (cnt_rd !== {CNT_W{1'b1}}) begin
         failures++;
         $display("FAIL saturate_allones: got=%h exp=all-ones", cnt_rd);
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      bus.ar_valid = 1'b1; bus.ar_id = 8'h3C; bus.ar_len = 8'd7; bus.ar_addr = $urandom;
      bus.r_ready = 1'b1;
      @(posedge clk);
      #1 bus.ar_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.r_valid, bus.r_last, bus.r_id} !== {2'b10, 8'h3C}) begin
         failures++;
         $display("FAIL midburst_beat2: got=%h exp=%h", {bus.r_valid, bus.r_last, bus.r_id}, {2'b10, 8'h3C});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.r_valid, bus.ar_ready} !== 2'b01) begin
         failures++;
         $display("FAIL midburst_async_reset: got {rv,arr}=%b exp=01", {bus.r_valid, bus.ar_ready});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.r_ready = 1'b0;
      checks++;
      if ({cnt_rd, err_valid, bus.ar_ready} !== {{CNT_W{1'b0}}, 2'b01}) begin
         failures++;
         $display("FAIL midburst_after_release: got cnt_rd=%0d ev=%b arr=%b exp 0/0/1",
                  cnt_rd, err_valid, bus.ar_ready);
      end
      m_wr = 0; m_rd = 0; m_cap_valid = 1'b0;
      ar_q.push_back(mk(8'h44, 8'd0));
      run_traffic(0, 100, 100, 0, 1'b0, 1'b0, 50, "post_reset_read");
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_bhold();
      test_long_burst();
      test_random();
      test_simultaneous_and_clear();
      test_saturate();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
